// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: accepts PCs, issues them to instruction memory, and pairs
// the in-order responses with their PCs in a DEPTH-entry circular queue that
// feeds the IF/ID boundary. A flush drops queued entries and records how many
// in-flight responses must still be swallowed.
module instr_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_req_valid,
  output logic               pc_req_ready,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               flush,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               if_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_pc    [DEPTH];
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_filled;
  logic [PTR_W-1:0]   r_alloc_ptr;
  logic [PTR_W-1:0]   r_fill_ptr;
  logic [PTR_W-1:0]   r_head_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_discard;

  logic               w_room;
  logic               w_accept;
  logic               w_drop;
  logic               w_fill;
  logic               w_pop;
  logic [CNT_W-1:0]   w_unfilled;

  // Issue handshake and head presentation; all gated off while in reset or flushing.
  always_comb begin
    w_room         = (({1'b0, r_count} + {1'b0, r_discard}) < DEPTH_C);
    pc_req_ready   = ~reset & imem_req_ready & w_room & ~flush;
    imem_req_valid = ~reset & pc_req_valid & w_room & ~flush;
    imem_req_addr  = pc_in;
    w_accept       = pc_req_valid & pc_req_ready;
    w_drop         = imem_rsp_valid & (r_discard != '0);
    w_fill         = imem_rsp_valid & (r_discard == '0) &
                     r_valid[r_fill_ptr] & ~r_filled[r_fill_ptr];
    if_valid       = ~reset & r_filled[r_head_ptr] & ~flush;
    if_pc          = r_pc[r_head_ptr];
    if_instr       = r_instr[r_head_ptr];
    w_pop          = if_valid & if_ready;
  end

  // Count of allocated entries still waiting for their response (pre-response state).
  always_comb begin
    w_unfilled = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !r_filled[i]) w_unfilled = w_unfilled + CNT_W'(1);
    end
  end

  // Queue state: allocation, in-order fill, pop, and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
      r_valid     <= '0;
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_discard   <= '0;
    end else if (flush) begin
      // A response arriving with the flush is consumed first, so it is not
      // counted again among the responses still owed.
      r_valid     <= '0;
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_discard   <= r_discard + w_unfilled - CNT_W'(w_drop | w_fill);
    end else begin
      if (w_accept) begin
        r_pc[r_alloc_ptr]     <= pc_in;
        r_valid[r_alloc_ptr]  <= 1'b1;
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
      if (w_fill) begin
        r_instr[r_fill_ptr]  <= imem_rsp_data;
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head_ptr]  <= 1'b0;
        r_filled[r_head_ptr] <= 1'b0;
        r_head_ptr           <= r_head_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a queue-level reference model of the fetch unit
// and a simple in-order instruction memory.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_req_valid;
  logic        pc_req_ready;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        flush;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_req_valid   (pc_req_valid),
    .pc_req_ready   (pc_req_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: queue of fetches in program order, plus owed-response count.
  logic [63:0] q_pc  [$];
  logic [31:0] q_ins [$];
  bit          q_fil [$];
  int          discard = 0;
  // Memory side: addresses whose response has not yet been returned.
  logic [63:0] owed  [$];
  logic [63:0] next_pc = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    case (a)
      64'h0:   w = 32'h0000_0013;
      64'h4:   w = 32'h0050_0093;
      64'h8:   w = 32'h00a0_0113;
      default: begin
        w = a[31:0] ^ 32'h9e37_79b9;
      end
    endcase
    return w;
  endfunction

  // One clock cycle: drive at the falling edge, check #1 later, advance the model
  // with what the rising edge will see.
  task automatic cyc(input bit rs, input bit pv, input bit fl, input bit ir,
                     input bit mrdy, input bit rsp_en, input bit stray);
    bit          rv;
    logic [31:0] rd;
    bit          room, e_rdy, e_ivld, e_ifv;
    int          idx;
    int          unf;
    rv = 1'b0;
    rd = $urandom;
    if (!rs && rsp_en && owed.size() > 0) begin
      rv = 1'b1;
      rd = mem_word(owed.pop_front());
    end else if (!rs && stray && owed.size() == 0) begin
      rv = 1'b1;
    end
    reset          = rs;
    pc_req_valid   = pv;
    pc_in          = next_pc;
    flush          = fl;
    if_ready       = ir;
    imem_req_ready = mrdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    #1;
    room   = (q_pc.size() + discard) < DEPTH;
    e_rdy  = !rs && mrdy && room && !fl;
    e_ivld = !rs && pv && room && !fl;
    e_ifv  = !rs && !fl && q_pc.size() > 0 && q_fil[0];
    chk("pc_req_ready",   64'(pc_req_ready),   64'(e_rdy));
    chk("imem_req_valid", 64'(imem_req_valid), 64'(e_ivld));
    if (e_ivld) chk("imem_req_addr", imem_req_addr, next_pc);
    chk("if_valid", 64'(if_valid), 64'(e_ifv));
    if (e_ifv) begin
      chk("if_pc",    if_pc,         q_pc[0]);
      chk("if_instr", 64'(if_instr), 64'(q_ins[0]));
    end
    if (rs) begin
      q_pc.delete(); q_ins.delete(); q_fil.delete();
      owed.delete();
      discard = 0;
    end else begin
      if (rv) begin
        if (discard > 0) discard--;
        else begin
          idx = -1;
          for (int i = 0; i < q_pc.size(); i++)
            if (idx < 0 && !q_fil[i]) idx = i;
          if (idx >= 0) begin
            q_ins[idx] = rd;
            q_fil[idx] = 1'b1;
          end
        end
      end
      if (fl) begin
        unf = 0;
        for (int i = 0; i < q_pc.size(); i++) if (!q_fil[i]) unf++;
        discard += unf;
        q_pc.delete(); q_ins.delete(); q_fil.delete();
      end else begin
        if (e_ifv && ir) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
          void'(q_fil.pop_front());
        end
        if (e_rdy && pv) begin
          q_pc.push_back(next_pc);
          q_ins.push_back('0);
          q_fil.push_back(1'b0);
          owed.push_back(next_pc);
          next_pc = next_pc + 64'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 1, 1, 0);
  endtask

  initial begin
    reset = 1'b1; pc_req_valid = 1'b0; pc_in = '0; flush = 1'b0; if_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);

    // 1: reset held with a pending request
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1, 1, 0);
    chk("reset_if_pc",    if_pc,         64'h0);
    chk("reset_if_instr", 64'(if_instr), 64'h0);

    // 2: streaming three PCs through a 1-cycle memory
    next_pc = 64'h0;
    for (int i = 0; i < 7; i++) cyc(0, next_pc < 64'hC, 0, 1, 1, 1, 0);
    idle(2);

    // 3: backpressure from decode fills the queue, then drains
    next_pc = 64'h0;
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 1, 0);
    chk("bp_pc_hold", pc_in, 64'h8);
    for (int i = 0; i < 3; i++) cyc(0, next_pc <= 64'h8, 0, 1, 1, 1, 0);
    idle(4);

    // 4: flush while two requests are in flight
    next_pc = 64'h10;
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    next_pc = 64'h100;
    for (int i = 0; i < 6; i++) cyc(0, next_pc == 64'h100, 0, 1, 1, 1, 0);
    idle(2);

    // 5: flush coincides with the only outstanding response
    next_pc = 64'h20;
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 1, 0);
    idle(3);

    // 6: reset with two queued entries, then a stray response
    next_pc = 64'h40;
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("midreset_if_pc", if_pc, 64'h0);
    cyc(0, 0, 0, 1, 1, 0, 1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rs, fl;
      rs = ($urandom_range(63) == 0);
      fl = ($urandom_range(9) == 0);
      cyc(rs, $urandom_range(3) != 0, fl, $urandom_range(3) != 0,
          $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(31) == 0);
      if (fl || rs) next_pc = {$urandom, $urandom} & ~64'h3;
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
